// File: rtl/iread_controller.sv
`default_nettype none
// iread_controller: read-side sequencer for the banked ping-pong IBRAM.
// Walks conv-window addresses across all banks in lockstep and tags returning data valid.
module iread_controller #(
  parameter  int NUM_BANKS       = 16,
  parameter  int IBRAM_DEPTH     = 1024,
  parameter  int MAX_IN_CHANNEL  = 45,
  parameter  int MAX_KERNEL_SIZE = 5,
  parameter  int MAX_OUT_SEQ     = 160,
  parameter  int BRAM_LATENCY    = 2,
  localparam int AW              = $clog2(IBRAM_DEPTH),
  localparam int CW              = $clog2(MAX_IN_CHANNEL + 1),
  localparam int KW              = $clog2(MAX_KERNEL_SIZE + 1),
  localparam int SW              = $clog2(MAX_OUT_SEQ + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        cfg_in_ch,
  input  logic [KW-1:0]        cfg_kernel,
  input  logic [SW-1:0]        cfg_out_seq,
  input  logic [AW-1:0]        cfg_base,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           buf_full,
  output logic [1:0]           buf_release,
  output logic [NUM_BANKS-1:0] enB,
  output logic [AW-1:0]        addrB,
  output logic                 ping_pong,
  output logic                 act_valid,
  input  logic                 act_ready,
  output logic                 layer_done
);

  localparam int DW = $clog2(BRAM_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_ISSUE    = 3'd2,
    S_DRAIN    = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           in_ch_q, in_ch_d;
  logic [KW-1:0]           kernel_q, kernel_d;
  logic [SW-1:0]           out_seq_q, out_seq_d;
  logic [AW-1:0]           row_base_q, row_base_d;
  logic [AW-1:0]           tap_base_q, tap_base_d;
  logic [CW-1:0]           c_q, c_d;
  logic [KW-1:0]           k_q, k_d;
  logic [SW-1:0]           pos_q, pos_d;
  logic [DW-1:0]           drain_q, drain_d;
  logic                    ping_pong_q, ping_pong_d;
  logic [BRAM_LATENCY-1:0] vld_q, vld_d;

  logic          issue_w;
  logic          last_c_w, last_k_w, last_pos_w, zero_cfg_w;
  logic [AW-1:0] in_ch_ext_w;

  assign issue_w     = (state_q == S_ISSUE) && act_ready;
  assign last_c_w    = (c_q + CW'(1)) == in_ch_q;
  assign last_k_w    = (k_q + KW'(1)) == kernel_q;
  assign last_pos_w  = (pos_q + SW'(1)) == out_seq_q;
  assign zero_cfg_w  = (in_ch_q == '0) || (kernel_q == '0) || (out_seq_q == '0);
  assign in_ch_ext_w = AW'(in_ch_q);

  assign enB       = {NUM_BANKS{issue_w}};
  assign addrB     = issue_w ? (tap_base_q + AW'(c_q)) : '0;
  assign ping_pong = ping_pong_q;
  assign act_valid = vld_q[BRAM_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ch_q     <= '0;
      kernel_q    <= '0;
      out_seq_q   <= '0;
      row_base_q  <= '0;
      tap_base_q  <= '0;
      c_q         <= '0;
      k_q         <= '0;
      pos_q       <= '0;
      drain_q     <= '0;
      ping_pong_q <= 1'b0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ch_q     <= in_ch_d;
      kernel_q    <= kernel_d;
      out_seq_q   <= out_seq_d;
      row_base_q  <= row_base_d;
      tap_base_q  <= tap_base_d;
      c_q         <= c_d;
      k_q         <= k_d;
      pos_q       <= pos_d;
      drain_q     <= drain_d;
      ping_pong_q <= ping_pong_d;
      vld_q       <= vld_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ch_d     = in_ch_q;
    kernel_d    = kernel_q;
    out_seq_d   = out_seq_q;
    row_base_d  = row_base_q;
    tap_base_d  = tap_base_q;
    c_d         = c_q;
    k_d         = k_q;
    pos_d       = pos_q;
    drain_d     = drain_q;
    ping_pong_d = ping_pong_q;
    cfg_ready   = 1'b0;
    buf_release = '0;
    layer_done  = 1'b0;
    // Read-data valid tracks the issued enable, independent of FSM state.
    vld_d       = vld_q << 1;
    vld_d[0]    = issue_w;

    case (state_q)
      S_IDLE: begin
        cfg_ready = ~rst;
        if (cfg_valid) begin
          in_ch_d    = cfg_in_ch;
          kernel_d   = cfg_kernel;
          out_seq_d  = cfg_out_seq;
          row_base_d = cfg_base;
          tap_base_d = cfg_base;
          c_d        = '0;
          k_d        = '0;
          pos_d      = '0;
          state_d    = S_WAIT_BUF;
        end
      end
      S_WAIT_BUF: begin
        if (zero_cfg_w) begin
          state_d = S_RELEASE;
        end else if (buf_full[ping_pong_q]) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (act_ready) begin
          if (!last_c_w) begin
            c_d = c_q + CW'(1);
          end else begin
            c_d = '0;
            if (!last_k_w) begin
              k_d        = k_q + KW'(1);
              tap_base_d = tap_base_q + in_ch_ext_w;
            end else begin
              k_d = '0;
              if (last_pos_w) begin
                drain_d = '0;
                state_d = S_DRAIN;
              end else begin
                // Next output position restarts its taps one row further on.
                pos_d      = pos_q + SW'(1);
                row_base_d = row_base_q + in_ch_ext_w;
                tap_base_d = row_base_q + in_ch_ext_w;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(BRAM_LATENCY - 1)) begin
          state_d = S_RELEASE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_RELEASE: begin
        buf_release[ping_pong_q] = 1'b1;
        layer_done               = 1'b1;
        ping_pong_d              = ~ping_pong_q;
        state_d                  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_iread_controller.sv
`default_nettype none
// Bench for iread_controller: directed layers checked every cycle against a loop-order
// address model, plus literal address/timing expectations per scenario.
module tb_iread_controller;
  localparam int NB    = 16;
  localparam int DEPTH = 1024;
  localparam int L     = 2;
  localparam int AW    = 10;
  localparam int CW    = 6;
  localparam int KW    = 3;
  localparam int SW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cfg_in_ch = '0;
  logic [KW-1:0] cfg_kernel = '0;
  logic [SW-1:0] cfg_out_seq = '0;
  logic [AW-1:0] cfg_base = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    buf_full = '0;
  logic [1:0]    buf_release;
  logic [NB-1:0] enB;
  logic [AW-1:0] addrB;
  logic          ping_pong;
  logic          act_valid;
  logic          act_ready = 1'b1;
  logic          layer_done;

  always #5 clk = ~clk;

  iread_controller #(
    .NUM_BANKS(NB), .IBRAM_DEPTH(DEPTH), .MAX_IN_CHANNEL(45),
    .MAX_KERNEL_SIZE(5), .MAX_OUT_SEQ(160), .BRAM_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_in_ch(cfg_in_ch), .cfg_kernel(cfg_kernel), .cfg_out_seq(cfg_out_seq),
    .cfg_base(cfg_base), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .buf_full(buf_full), .buf_release(buf_release),
    .enB(enB), .addrB(addrB), .ping_pong(ping_pong),
    .act_valid(act_valid), .act_ready(act_ready), .layer_done(layer_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: addresses still owed, enable history, current half.
  int         exp_q[$];
  logic [L-1:0] hist = '0;
  logic       m_half = 1'b0;
  logic       prev_av = 1'b0;
  int         m_beats = 0;
  int         cyc = 0;
  int         cap_addr[$];
  int         en_count = 0, av_count = 0, rel_count = 0;
  int         first_en = -1, last_en = -1, first_av = -1, last_av = -1;
  logic [1:0] last_rel = '0;
  logic       done_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("enB_uniform", 32'((enB == '0) || (&enB)), 32'd1);
    chk("act_valid", 32'(act_valid), 32'(hist[L-1]));
    chk("ping_pong", 32'(ping_pong), 32'(m_half));
    chk("done_eq_release", 32'(layer_done), 32'(|buf_release));
    if (enB[0]) begin
      cap_addr.push_back(int'(addrB));
      en_count++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (exp_q.size() == 0) chk("enB_unexpected", 32'd1, 32'd0);
      else chk("addrB", 32'(addrB), 32'(exp_q.pop_front()));
    end
    if (act_valid) begin
      av_count++;
      if (first_av < 0) first_av = cyc;
      last_av = cyc;
    end
    if (layer_done) begin
      chk("release_half", 32'(buf_release), m_half ? 32'd2 : 32'd1);
      chk("beats_left_at_done", 32'(exp_q.size()), 32'd0);
      chk("inflight_at_done", 32'(hist), 32'd0);
      chk("done_after_last_valid", 32'(prev_av), 32'(m_beats > 0));
      last_rel  = buf_release;
      rel_count++;
      done_seen = 1'b1;
      m_half    = ~m_half;
    end
    prev_av = act_valid;
    hist    = hist << 1;
    hist[0] = enB[0];
    if (rst) begin
      hist   = '0;
      exp_q.delete();
      m_half = 1'b0;
      prev_av = 1'b0;
    end
  end

  task automatic load_model(input int ic, input int kk, input int sq, input int base);
    m_beats = ic * kk * sq;
    for (int p = 0; p < sq; p++)
      for (int k = 0; k < kk; k++)
        for (int c = 0; c < ic; c++)
          exp_q.push_back((base + (p + k) * ic + c) % DEPTH);
    cap_addr.delete();
    en_count = 0; av_count = 0;
    first_en = -1; last_en = -1; first_av = -1; last_av = -1;
    done_seen = 1'b0;
  endtask

  task automatic start_layer(input int ic, input int kk, input int sq, input int base);
    int guard = 0;
    while (cfg_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    load_model(ic, kk, sq, base);
    cfg_in_ch   = CW'(ic);
    cfg_kernel  = KW'(kk);
    cfg_out_seq = SW'(sq);
    cfg_base    = AW'(base);
    cfg_valid   = 1'b1;
    @(posedge clk); #1;
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while (!done_seen && guard < 2000) begin
      @(posedge clk); #1; guard++;
    end
    chk({name, "_layer_done_seen"}, 32'(done_seen), 32'd1);
  endtask

  task automatic chk_addrs(input string name, input int exp[8]);
    chk({name, "_enB_count"}, 32'(cap_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk({name, "_addr_seq"}, (i < cap_addr.size()) ? 32'(cap_addr[i]) : 32'hFFFF_FFFF,
          32'(exp[i]));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
    chk({name, "_enB"}, 32'(enB), 32'd0);
    chk({name, "_addrB"}, 32'(addrB), 32'd0);
    chk({name, "_ping_pong"}, 32'(ping_pong), 32'd0);
    chk({name, "_act_valid"}, 32'(act_valid), 32'd0);
    chk({name, "_layer_done"}, 32'(layer_done), 32'd0);
    chk({name, "_buf_release"}, 32'(buf_release), 32'd0);
  endtask

  int seq1[8] = '{0, 1, 2, 3, 2, 3, 4, 5};
  int seq5[8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
  int rel_before;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Layer on half 0, full-rate consumer.
    buf_full = 2'b01;
    start_layer(2, 2, 2, 0);
    wait_done("t1");
    chk_addrs("t1", seq1);
    chk("t1_av_count", 32'(av_count), 32'd8);
    chk("t1_av_latency", 32'(first_av - first_en), 32'd2);
    chk("t1_av_contiguous", 32'(last_av - first_av), 32'd7);
    chk("t1_release", 32'(last_rel), 32'd1);
    chk("t1_ping_pong_after", 32'(ping_pong), 32'd1);

    // Half 1 not yet written: must wait.
    start_layer(2, 2, 2, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t3_no_issue_while_empty", 32'(en_count), 32'd0);
    chk("t3_not_ready_while_waiting", 32'(cfg_ready), 32'd0);
    buf_full = 2'b11;
    wait_done("t3");
    chk_addrs("t3", seq1);
    chk("t3_release", 32'(last_rel), 32'd2);

    // Back on half 0 with a 3-cycle stall after three beats.
    begin
      int guard = 0;
      start_layer(2, 2, 2, 0);
      while (en_count < 3 && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      act_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t2_hold_during_stall", 32'(en_count), 32'd3);
      act_ready = 1'b1;
    end
    wait_done("t2");
    chk_addrs("t2", seq1);
    chk("t2_issue_span", 32'(last_en - first_en), 32'd10);
    chk("t2_av_count", 32'(av_count), 32'd8);
    chk("t2_release", 32'(last_rel), 32'd1);

    // Zero-kernel layer on half 1.
    rel_before = rel_count;
    start_layer(2, 0, 2, 0);
    wait_done("t4");
    chk("t4_enB_count", 32'(en_count), 32'd0);
    chk("t4_av_count", 32'(av_count), 32'd0);
    chk("t4_release", 32'(last_rel), 32'd2);
    chk("t4_release_once", 32'(rel_count - rel_before), 32'd1);
    chk("t4_ping_pong_after", 32'(ping_pong), 32'd0);

    // Address wrap at the top of the half.
    start_layer(4, 1, 2, 1020);
    wait_done("t5");
    chk_addrs("t5", seq5);
    chk("t5_release", 32'(last_rel), 32'd1);

    // Reset mid-layer on half 1.
    begin
      int guard = 0;
      start_layer(2, 2, 2, 0);
      while (en_count < 5 && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      chk("t6_reached_beat5", 32'(en_count), 32'd5);
    end
    rel_before = rel_count;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("t6_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_release", 32'(rel_count - rel_before), 32'd0);
    buf_full = 2'b01;
    start_layer(2, 2, 2, 0);
    wait_done("t6_fresh");
    chk_addrs("t6_fresh", seq1);
    chk("t6_fresh_release", 32'(last_rel), 32'd1);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
